bram_scan: RTL and testbench

BRAM_SCAN -- requirements
Module: bram_scan

---
 rtl/bram_scan.sv | 148 ++++++++++++++
 tb/tb_bram_scan.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_scan.sv
// bram_scan: walks a BRAM address range, latching {addr, data} for a hex display.
// Optional BRAM_SCAN_WRAP_EN: wrap from LAST_ADDR to 0 instead of halting.
module bram_scan #(
  parameter int ADDR_W    = 11,
  parameter int DATA_W    = 8,
  parameter int LAST_ADDR = 2047,
  parameter int TICK_DIV  = 50000000,
  parameter int RD_LAT    = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              run,
  input  logic              step,
  input  logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  output logic              regce,
  output logic [15:0]       hex_val,
  output logic              valid,
  output logic              done
);

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam logic [TICK_W-1:0] TICK_MAX =
    TICK_W'(TICK_DIV - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST =
    ADDR_W'(LAST_ADDR);
  localparam logic [1:0] WAIT_MAX =
    2'((RD_LAT > 1) ? RD_LAT - 2 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_HOLD
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rd_en_q, rd_en_d;
  logic [15:0]         hex_q, hex_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [1:0]          wait_q, wait_d;

  logic                at_last;
  logic                tick_hit;
  logic                advance;
  logic [ADDR_W-1:0]   addr_next;
  logic [7:0]          addr8;
  logic [7:0]          data8;

  always_comb begin
    at_last  = (addr_q == ADDR_LAST);
    tick_hit = run && (tick_q == TICK_MAX);
    addr8    = 8'(addr_q);
    data8    = 8'(rd_data);
`ifdef BRAM_SCAN_WRAP_EN
    advance   = step || tick_hit;
    addr_next = at_last ? '0 : addr_q + 1'b1;
`else
    // the last address is terminal: HOLD no longer listens to run/step
    advance   = !at_last && (step || tick_hit);
    addr_next = addr_q + 1'b1;
`endif
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    hex_d   = hex_q;
    valid_d = valid_q;
    done_d  = done_q;
    tick_d  = tick_q;
    wait_d  = wait_q;
    unique case (state_q)
      S_IDLE: begin
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        wait_d  = '0;
        state_d = (RD_LAT > 1) ? S_WAIT : S_CAPTURE;
      end
      S_WAIT: begin
        if (wait_q == WAIT_MAX) begin
          state_d = S_CAPTURE;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      S_CAPTURE: begin
        hex_d   = {addr8, data8};
        valid_d = 1'b1;
        tick_d  = '0;
        state_d = S_HOLD;
`ifndef BRAM_SCAN_WRAP_EN
        if (at_last) begin
          done_d = 1'b1;
        end
`endif
      end
      S_HOLD: begin
        tick_d = run ? tick_q + 1'b1 : '0;
        if (advance) begin
          tick_d  = '0;
          addr_d  = addr_next;
          state_d = S_ISSUE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    rd_en_d = (state_d == S_ISSUE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rd_en_q <= 1'b0;
      hex_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      tick_q  <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rd_en_q <= rd_en_d;
      hex_q   <= hex_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      tick_q  <= tick_d;
      wait_q  <= wait_d;
    end
  end

  assign rd_addr = addr_q;
  assign rd_en   = rd_en_q;
  assign regce   = (RD_LAT == 2);
  assign hex_val = hex_q;
  assign valid   = valid_q;
  assign done    = done_q;

endmodule

// File: tb/tb_bram_scan.sv
// tb_bram_scan: directed + random run/step stimulus against a
// transaction-level model of the scan (address order, capture timing).
module tb_bram_scan;

  localparam int AW   = 11;
  localparam int DW   = 8;
  localparam int LAST = 3;
  localparam int TDIV = 4;
  localparam int LAT  = 2;
`ifdef BRAM_SCAN_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          run;
  logic          step;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] rd_addr;
  logic          rd_en;
  logic          regce;
  logic [15:0]   hex_val;
  logic          valid;
  logic          done;

  always #5 clk = ~clk;

  bram_scan #(
    .ADDR_W(AW), .DATA_W(DW), .LAST_ADDR(LAST),
    .TICK_DIV(TDIV), .RD_LAT(LAT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .step(step),
    .rd_data(rd_data), .rd_addr(rd_addr), .rd_en(rd_en),
    .regce(regce), .hex_val(hex_val), .valid(valid),
    .done(done)
  );

  // BRAM: latch stage on RDEN, output register on REGCE; data = addr ^ A5
  logic [7:0] s1, s2;
  always @(posedge clk) begin
    if (rd_en) s1 <= 8'(rd_addr) ^ 8'hA5;
    if (regce) s2 <= s1;
  end
  assign rd_data = s2;

  typedef struct {
    int addr;
    int due;
  } rd_t;

  rd_t         pend[$];
  logic [15:0] hex_seq[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc_n = 0;
  int          run_cnt = 0;
  int          n_issue = 0;
  int          exp_addr = 0;
  int          cur_addr = 0;
  bit          first = 1'b1;
  bit          halted = 1'b0;
  logic        prev_en = 1'b0;
  logic [15:0] exp_hex = '0;
  logic [15:0] last_hex = '0;
  logic        exp_valid = 1'b0;
  logic        exp_done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] word(input int a);
    logic [7:0] lo;
    lo = 8'(a);
    return {lo, lo ^ 8'hA5};
  endfunction

  task automatic model_reset();
    pend.delete();
    hex_seq.delete();
    exp_addr  = 0;
    cur_addr  = 0;
    first     = 1'b1;
    halted    = 1'b0;
    prev_en   = 1'b0;
    exp_hex   = '0;
    last_hex  = '0;
    exp_valid = 1'b0;
    exp_done  = 1'b0;
    run_cnt   = 0;
  endtask

  // called at each negedge; run/step still hold the previous cycle's values
  task automatic monitor();
    int a;
    cyc_n++;
    run_cnt = run ? run_cnt + 1 : 0;
    if (pend.size() > 0 && pend[0].due == cyc_n) begin
      a = pend[0].addr;
      void'(pend.pop_front());
      exp_hex   = word(a);
      exp_valid = 1'b1;
      if (!WRAP && a == LAST) exp_done = 1'b1;
    end
    if (rd_en === 1'b1) begin
      n_issue++;
      chk("issue_after_halt", 32'(halted), 0);
      chk("issue_addr", 32'(rd_addr), exp_addr);
      chk("issue_cause",
          32'(first || step || run_cnt >= TDIV), 1);
      chk("issue_overlap", pend.size(), 0);
      pend.push_back('{addr: exp_addr, due: cyc_n + LAT + 1});
      cur_addr = exp_addr;
      if (exp_addr == LAST) begin
        if (WRAP) exp_addr = 0;
        else halted = 1'b1;
      end else begin
        exp_addr++;
      end
      first = 1'b0;
    end else begin
      chk("addr_hold", 32'(rd_addr), cur_addr);
    end
    chk("rd_en_pulse", 32'(prev_en && rd_en), 0);
    prev_en = rd_en;
    chk("hex_val", 32'(hex_val), 32'(exp_hex));
    chk("valid", 32'(valid), 32'(exp_valid));
    chk("done", 32'(done), 32'(exp_done));
    if (valid === 1'b1 && hex_val !== last_hex) begin
      hex_seq.push_back(hex_val);
      last_hex = hex_val;
    end
  endtask

  task automatic cyc(input logic r, input logic s);
    @(negedge clk);
    monitor();
    run  = r;
    step = s;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0);
  endtask

  task automatic pulse_step();
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
  endtask

  // must be called right after cyc(); drops reset mid-cycle
  task automatic do_reset(input int hold);
    #2 reset_n = 1'b0;
    run  = 1'b0;
    step = 1'b0;
    #1;
    chk("async_rd_en", 32'(rd_en), 0);
    chk("async_rd_addr", 32'(rd_addr), 0);
    chk("async_hex", 32'(hex_val), 0);
    chk("async_valid", 32'(valid), 0);
    chk("async_done", 32'(done), 0);
    model_reset();
    idle(hold);
    reset_n = 1'b1;
  endtask

  initial begin
    int exp_a4;
    int exp_a5;
    logic [15:0] exp_h4;
    logic [15:0] exp_h5;
    reset_n = 1'b0;
    run     = 1'b0;
    step    = 1'b0;
    model_reset();
    idle(3);
    chk("rst_hex", 32'(hex_val), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_rd_en", 32'(rd_en), 0);
    chk("regce", 32'(regce), 1);
    reset_n = 1'b1;

    // single read after reset, no further reads with run=0
    cyc(1'b0, 1'b0);
    chk("first_issue", 32'(rd_en), 1);
    idle(LAT);
    chk("not_yet_valid", 32'(valid), 0);
    cyc(1'b0, 1'b0);
    chk("first_hex", 32'(hex_val), 16'h00A5);
    chk("first_valid", 32'(valid), 1);
    idle(10);
    chk("single_read", n_issue, 1);

    // step in HOLD advances once; step in WAIT is ignored
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    chk("step_issue", 32'(rd_en), 1);
    cyc(1'b0, 1'b1);
    idle(10);
    chk("wait_step_reads", n_issue, 2);
    chk("wait_step_addr", 32'(rd_addr), 1);
    chk("wait_step_hex", 32'(hex_val), 16'h01A4);
    pulse_step();
    idle(8);
    chk("step2_hex", 32'(hex_val), 16'h02A7);

    // auto-advance with run held high
    do_reset(2);
    repeat (40) cyc(1'b1, 1'b0);
    chk("run_seq0", 32'(hex_seq[0]), 16'h00A5);
    chk("run_seq1", 32'(hex_seq[1]), 16'h01A4);
    chk("run_seq2", 32'(hex_seq[2]), 16'h02A7);
    idle(12);

    // end-of-range behaviour with four steps
    do_reset(2);
    idle(6);
    repeat (4) begin
      pulse_step();
      idle(6);
    end
    exp_a4 = WRAP ? 0 : LAST;
    exp_h4 = WRAP ? 16'h00A5 : 16'h03A6;
    chk("end_addr", 32'(rd_addr), exp_a4);
    chk("end_hex", 32'(hex_val), 32'(exp_h4));
    chk("end_done", 32'(done), 32'(!WRAP));
    pulse_step();
    idle(8);
    exp_a5 = WRAP ? 1 : LAST;
    exp_h5 = WRAP ? 16'h01A4 : 16'h03A6;
    chk("end_addr2", 32'(rd_addr), exp_a5);
    chk("end_hex2", 32'(hex_val), 32'(exp_h5));

    // reset during WAIT of address 2
    do_reset(2);
    idle(6);
    pulse_step();
    idle(5);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    chk("pre_rst_issue", 32'(rd_en), 1);
    chk("pre_rst_addr", 32'(rd_addr), 2);
    cyc(1'b0, 1'b0);
    do_reset(2);
    idle(LAT + 2);
    chk("post_rst_hex", 32'(hex_val), 16'h00A5);
    chk("post_rst_addr", 32'(rd_addr), 0);

    // random run/step/reset traffic
    for (int i = 0; i < 400; i++) begin
      logic r;
      logic s;
      r = ($urandom_range(0, 15) == 0) ? !run : run;
      s = ($urandom_range(0, 5) == 0);
      cyc(r, s);
      if ($urandom_range(0, 119) == 0) do_reset($urandom_range(1, 2));
    end
    idle(12);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
